// File: rtl/axi_scratchpad_responder.sv
// AXI4 subordinate backed by a single-ported 64-bit scratchpad; one burst in flight.
// Define AXI_SCRATCHPAD_WRAP_EN to support WRAP bursts (otherwise they answer SLVERR).
module axi_scratchpad_responder #(
  parameter logic [63:0] BaseAddr = 64'h8000_0000,
  parameter int unsigned NumWords = 1024,
  parameter int unsigned IdWidth  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               aw_valid_i,
  output logic               aw_ready_o,
  input  logic [IdWidth-1:0] aw_id_i,
  input  logic [63:0]        aw_addr_i,
  input  logic [7:0]         aw_len_i,
  input  logic [2:0]         aw_size_i,
  input  logic [1:0]         aw_burst_i,
  input  logic               w_valid_i,
  output logic               w_ready_o,
  input  logic [63:0]        w_data_i,
  input  logic [7:0]         w_strb_i,
  input  logic               w_last_i,
  output logic               b_valid_o,
  input  logic               b_ready_i,
  output logic [IdWidth-1:0] b_id_o,
  output logic [1:0]         b_resp_o,
  input  logic               ar_valid_i,
  output logic               ar_ready_o,
  input  logic [IdWidth-1:0] ar_id_i,
  input  logic [63:0]        ar_addr_i,
  input  logic [7:0]         ar_len_i,
  input  logic [2:0]         ar_size_i,
  input  logic [1:0]         ar_burst_i,
  output logic               r_valid_o,
  input  logic               r_ready_i,
  output logic [IdWidth-1:0] r_id_o,
  output logic [63:0]        r_data_o,
  output logic [1:0]         r_resp_o,
  output logic               r_last_o
);
  localparam int unsigned AW       = $clog2(NumWords);
  localparam logic [63:0] MemBytes = 64'(NumWords) * 64'd8;
`ifdef AXI_SCRATCHPAD_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_e;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [63:0]        addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic [7:0]         cnt;
    logic               err;
  } txn_t;

  // Burst-wide attributes that make every beat an error.
  function automatic logic burst_bad(input txn_t t);
    logic len_ok;
    len_ok = (t.len == 8'd1) || (t.len == 8'd3) || (t.len == 8'd7) || (t.len == 8'd15);
    return (t.size > 3'd3) || (t.burst == 2'b11) ||
           ((t.burst == 2'b10) && (!WrapEn || !len_ok));
  endfunction

  function automatic logic out_of_range(input logic [63:0] addr);
    return (addr < BaseAddr) || ((addr - BaseAddr) >= MemBytes);
  endfunction

  function automatic logic [AW-1:0] widx(input logic [63:0] addr);
    return AW'((addr - BaseAddr) >> 3);
  endfunction

  function automatic logic [63:0] next_addr(input txn_t t);
    logic [63:0] step, nxt;
    step = 64'd1 << t.size;
    nxt  = t.addr + step;
    if (t.burst == 2'b00) nxt = t.addr;
`ifdef AXI_SCRATCHPAD_WRAP_EN
    else if (t.burst == 2'b10) begin
      logic [63:0] mask;
      mask = ((64'(t.len) + 64'd1) << t.size) - 64'd1;
      nxt  = (t.addr & ~mask) | ((t.addr + step) & mask);
    end
`endif
    return nxt;
  endfunction

  state_e      state;
  txn_t        t, ar_req, aw_req;
  logic        last_wr;
  logic [63:0] mem [NumWords];

  assign ar_req = '{id: ar_id_i, addr: ar_addr_i, len: ar_len_i, size: ar_size_i,
                    burst: ar_burst_i, cnt: 8'd0, err: 1'b0};
  assign aw_req = '{id: aw_id_i, addr: aw_addr_i, len: aw_len_i, size: aw_size_i,
                    burst: aw_burst_i, cnt: 8'd0, err: 1'b0};

  // Reads win a tie unless the previous transaction was a read.
  logic rd_sel, wr_sel;
  assign rd_sel     = ar_valid_i && (!aw_valid_i || last_wr);
  assign wr_sel     = aw_valid_i && !rd_sel;
  assign ar_ready_o = (state == IDLE) && rd_sel;
  assign aw_ready_o = (state == IDLE) && wr_sel;
  assign w_ready_o  = (state == WRITE);

  logic ar_hs, aw_hs, w_hs;
  assign ar_hs = ar_valid_i && ar_ready_o;
  assign aw_hs = aw_valid_i && aw_ready_o;
  assign w_hs  = w_valid_i && w_ready_o;

  // One read port: first beat from AR in IDLE, following beats from the stepped address.
  logic [63:0] rd_addr, rd_word;
  logic        rd_err;
  assign rd_addr = (state == READ) ? next_addr(t) : ar_addr_i;
  assign rd_err  = ((state == READ) ? burst_bad(t) : burst_bad(ar_req)) || out_of_range(rd_addr);
  assign rd_word = rd_err ? 64'd0 : mem[widx(rd_addr)];

  logic wr_err, we;
  assign wr_err = burst_bad(t) || out_of_range(t.addr) || (w_last_i != (t.cnt == t.len));
  assign we     = w_hs && !wr_err;

  always_ff @(posedge clk_i) begin
    if (we)
      for (int b = 0; b < 8; b++)
        if (w_strb_i[b]) mem[widx(t.addr)][8*b +: 8] <= w_data_i[8*b +: 8];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      last_wr   <= 1'b1;
      t         <= '0;
      b_valid_o <= 1'b0;
      b_id_o    <= '0;
      b_resp_o  <= 2'b00;
      r_valid_o <= 1'b0;
      r_id_o    <= '0;
      r_data_o  <= 64'd0;
      r_resp_o  <= 2'b00;
      r_last_o  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ar_hs) begin
            t         <= ar_req;
            last_wr   <= 1'b0;
            state     <= READ;
            r_valid_o <= 1'b1;
            r_id_o    <= ar_id_i;
            r_data_o  <= rd_word;
            r_resp_o  <= rd_err ? 2'b10 : 2'b00;
            r_last_o  <= (ar_len_i == 8'd0);
          end else if (aw_hs) begin
            t       <= aw_req;
            last_wr <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (w_hs) begin
            t.cnt  <= t.cnt + 8'd1;
            t.addr <= next_addr(t);
            if (wr_err) t.err <= 1'b1;
            if (t.cnt == t.len) begin
              state     <= WRESP;
              b_valid_o <= 1'b1;
              b_id_o    <= t.id;
              b_resp_o  <= (t.err || wr_err) ? 2'b10 : 2'b00;
            end
          end
        end
        WRESP: begin
          if (b_ready_i) begin
            b_valid_o <= 1'b0;
            state     <= IDLE;
          end
        end
        READ: begin
          if (r_ready_i) begin
            if (t.cnt == t.len) begin
              r_valid_o <= 1'b0;
              r_last_o  <= 1'b0;
              state     <= IDLE;
            end else begin
              t.cnt    <= t.cnt + 8'd1;
              t.addr   <= rd_addr;
              r_data_o <= rd_word;
              r_resp_o <= rd_err ? 2'b10 : 2'b00;
              r_last_o <= ((t.cnt + 8'd1) == t.len);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
